gpu_command_transmitter: RTL and testbench

// - Host-side encoder/serializer for the GPU's UART command link; the transmit end of the byte

---
 rtl/gpu_command_transmitter.sv | 171 +++++++++++++++++
 tb/tb_gpu_command_transmitter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_command_transmitter.sv
// GPU command transmitter: accepts one pixel-write command per valid/ready handshake and
// serializes it as a fixed byte frame over an 8N1 UART line.
// Frame: 0x01, addr[23:16], addr[15:8], addr[7:0], data16[15:8], data16[7:0].
// Optional feature macro GPU_CMD_CHECKSUM_EN appends an XOR checksum byte of the frame.
module gpu_command_transmitter #(
  parameter int unsigned CLKS_PER_BIT      = 868,
  parameter int unsigned BITS_PER_PIXEL    = 12,
  parameter int unsigned FRAMEBUFFER_DEPTH = 307200
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Cmd_Valid,
  output logic                      o_Cmd_Ready,
  input  logic [31:0]               i_Cmd_Addr,
  input  logic [BITS_PER_PIXEL-1:0] i_Cmd_Data,
  output logic                      o_Uart_Tx,
  output logic                      o_Busy,
  output logic                      o_Frame_Done,
  output logic                      o_Cmd_Error
);

`ifdef GPU_CMD_CHECKSUM_EN
  localparam int unsigned NBYTES = 7;
`else
  localparam int unsigned NBYTES = 6;
`endif

  localparam int unsigned FrameW = NBYTES * 8;
  localparam int unsigned BaudW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW   = $clog2(NBYTES);

  localparam logic [BaudW-1:0] BaudMax  = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0]  LastByte = IdxW'(NBYTES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e              state_q, state_d;
  logic [BaudW-1:0]    baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [IdxW-1:0]     byte_idx_q, byte_idx_d;
  // Current byte always sits in frame_q[7:0]; the frame shifts down one byte per stop bit.
  logic [FrameW-1:0]   frame_q, frame_d;
  logic                frame_done_q, frame_done_d;
  logic                cmd_error_q, cmd_error_d;

  logic                accept;
  logic                addr_out_of_range;
  logic                baud_tick;
  logic [15:0]         data16;
  logic [FrameW-1:0]   new_frame;

  assign o_Cmd_Ready  = (state_q == StIdle) && !i_Reset;
  assign o_Busy       = (state_q != StIdle);
  assign o_Frame_Done = frame_done_q;
  assign o_Cmd_Error  = cmd_error_q;

  assign accept            = i_Cmd_Valid && o_Cmd_Ready;
  assign addr_out_of_range = (|i_Cmd_Addr[31:24]) || (i_Cmd_Addr >= FRAMEBUFFER_DEPTH);
  assign baud_tick         = (baud_q == BaudMax);
  assign data16            = 16'(i_Cmd_Data);

  // Assemble the outgoing frame from the command inputs, byte 0 in the low bits.
`ifdef GPU_CMD_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum  = 8'h01 ^ i_Cmd_Addr[23:16] ^ i_Cmd_Addr[15:8] ^ i_Cmd_Addr[7:0] ^
                     data16[15:8] ^ data16[7:0];
  assign new_frame = {checksum, data16[7:0], data16[15:8], i_Cmd_Addr[7:0],
                      i_Cmd_Addr[15:8], i_Cmd_Addr[23:16], 8'h01};
`else
  assign new_frame = {data16[7:0], data16[15:8], i_Cmd_Addr[7:0],
                      i_Cmd_Addr[15:8], i_Cmd_Addr[23:16], 8'h01};
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= StIdle;
      baud_q       <= '0;
      bit_q        <= '0;
      byte_idx_q   <= '0;
      frame_q      <= '0;
      frame_done_q <= 1'b0;
      cmd_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      byte_idx_q   <= byte_idx_d;
      frame_q      <= frame_d;
      frame_done_q <= frame_done_d;
      cmd_error_q  <= cmd_error_d;
    end
  end

  // Next-state logic: handshake, range check, bit/byte sequencing.
  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    byte_idx_d   = byte_idx_q;
    frame_d      = frame_q;
    frame_done_d = 1'b0;
    cmd_error_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (addr_out_of_range) begin
            // Consumed but dropped; stay idle so the next command can follow immediately.
            cmd_error_d = 1'b1;
          end else begin
            state_d    = StStart;
            frame_d    = new_frame;
            byte_idx_d = '0;
            baud_d     = '0;
            bit_d      = '0;
          end
        end
      end
      StStart: begin
        if (baud_tick) begin
          state_d = StData;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_tick) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_tick) begin
          baud_d = '0;
          if (byte_idx_q == LastByte) begin
            state_d      = StIdle;
            frame_done_d = 1'b1;
          end else begin
            state_d    = StStart;
            byte_idx_d = byte_idx_q + IdxW'(1);
            frame_d    = frame_q >> 8;
            bit_d      = '0;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Serial line driven from state; idle and stop bits are high.
  always_comb begin
    o_Uart_Tx = 1'b1;
    case (state_q)
      StStart: o_Uart_Tx = 1'b0;
      StData:  o_Uart_Tx = frame_q[bit_q];
      default: o_Uart_Tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_gpu_command_transmitter.sv
// Self-checking bench for gpu_command_transmitter (CLKS_PER_BIT=4).
// Reference model: each accepted command expands into a per-cycle queue of expected line levels.
// An independent UART decoder reconstructs bytes from the line for frame-content checks.
module tb_gpu_command_transmitter;
  localparam int unsigned CPB = 4;
  localparam int unsigned BPP = 12;
  localparam int unsigned FBD = 307200;
`ifdef GPU_CMD_CHECKSUM_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif

  logic           i_Clock = 1'b0;
  logic           i_Reset;
  logic           i_Cmd_Valid;
  logic           o_Cmd_Ready;
  logic [31:0]    i_Cmd_Addr;
  logic [BPP-1:0] i_Cmd_Data;
  logic           o_Uart_Tx;
  logic           o_Busy;
  logic           o_Frame_Done;
  logic           o_Cmd_Error;

  gpu_command_transmitter #(
    .CLKS_PER_BIT      (CPB),
    .BITS_PER_PIXEL    (BPP),
    .FRAMEBUFFER_DEPTH (FBD)
  ) dut (
    .i_Clock      (i_Clock),
    .i_Reset      (i_Reset),
    .i_Cmd_Valid  (i_Cmd_Valid),
    .o_Cmd_Ready  (o_Cmd_Ready),
    .i_Cmd_Addr   (i_Cmd_Addr),
    .i_Cmd_Data   (i_Cmd_Data),
    .o_Uart_Tx    (o_Uart_Tx),
    .o_Busy       (o_Busy),
    .o_Frame_Done (o_Frame_Done),
    .o_Cmd_Error  (o_Cmd_Error)
  );

  always #5 i_Clock = ~i_Clock;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame byte k for a command, straight from the frame format rules.
  function automatic logic [7:0] frame_byte(input logic [31:0] a, input logic [BPP-1:0] d,
                                            input int k);
    logic [7:0]  b [7];
    logic [15:0] d16;
    d16  = 16'(d);
    b[0] = 8'h01;
    b[1] = a[23:16];
    b[2] = a[15:8];
    b[3] = a[7:0];
    b[4] = d16[15:8];
    b[5] = d16[7:0];
    b[6] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
    return b[k];
  endfunction

  // Reference model: queue of line levels, one entry per cycle of the frame.
  logic       mq[$];
  logic [7:0] exp_bytes[$];
  bit         m_done, m_err, m_had;
  logic [7:0] m_byte;

  always @(posedge i_Clock) begin
    if (i_Reset) begin
      mq.delete();
      m_done = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      m_had  = (mq.size() > 0);
      if (m_had) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = 1'b1;
      end else if (i_Cmd_Valid) begin
        if (i_Cmd_Addr >= FBD) begin
          m_err = 1'b1;
        end else begin
          for (int k = 0; k < NB; k++) begin
            m_byte = frame_byte(i_Cmd_Addr, i_Cmd_Data, k);
            exp_bytes.push_back(m_byte);
            for (int c = 0; c < CPB; c++) mq.push_back(1'b0);
            for (int i = 0; i < 8; i++)
              for (int c = 0; c < CPB; c++) mq.push_back(m_byte[i]);
            for (int c = 0; c < CPB; c++) mq.push_back(1'b1);
          end
        end
      end
    end
  end

  // Per-cycle compare of every output against the model, plus activity counters.
  int busy_cycles = 0;
  int done_cnt    = 0;
  int err_cnt     = 0;

  always @(negedge i_Clock) begin
    if (cmp_en) begin
      chk("tx",    o_Uart_Tx,    (mq.size() > 0) ? mq[0] : 1'b1);
      chk("busy",  o_Busy,       (mq.size() > 0));
      chk("ready", o_Cmd_Ready,  (mq.size() == 0) && !i_Reset);
      chk("done",  o_Frame_Done, m_done);
      chk("error", o_Cmd_Error,  m_err);
      if (o_Busy === 1'b1)       busy_cycles++;
      if (o_Frame_Done === 1'b1) done_cnt++;
      if (o_Cmd_Error === 1'b1)  err_cnt++;
    end
  end

  // Independent UART line decoder, sampling mid-bit.
  bit         dec_active = 1'b0;
  int         dec_cnt;
  int         dec_slot;
  logic [7:0] dec_byte;
  logic [7:0] dec_q[$];

  always @(negedge i_Clock) begin
    if (!cmp_en || i_Reset) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (o_Uart_Tx === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
      end
    end else begin
      dec_cnt++;
      if ((dec_cnt % CPB) == (CPB / 2)) begin
        dec_slot = dec_cnt / CPB;
        if (dec_slot == 0) chk("start_bit", o_Uart_Tx, 1'b0);
        else if (dec_slot <= 8) dec_byte[dec_slot-1] = o_Uart_Tx;
        else begin
          chk("stop_bit", o_Uart_Tx, 1'b1);
          dec_q.push_back(dec_byte);
          dec_active = 1'b0;
        end
      end
    end
  end

  task automatic clr();
    busy_cycles = 0;
    done_cnt    = 0;
    err_cnt     = 0;
    dec_q.delete();
    exp_bytes.delete();
  endtask

  // Present a command and hold valid until an edge accepts it.
  task automatic send(input logic [31:0] a, input logic [BPP-1:0] d, input bit keep);
    int n;
    @(posedge i_Clock);
    #1;
    i_Cmd_Valid = 1'b1;
    i_Cmd_Addr  = a;
    i_Cmd_Data  = d;
    n = 0;
    forever begin
      @(negedge i_Clock);
      if (o_Cmd_Ready === 1'b1) break;
      n++;
      if (n > 5000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: ready never seen, got %b required 1", o_Cmd_Ready);
        break;
      end
    end
    @(posedge i_Clock);
    #1;
    if (!keep) i_Cmd_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge i_Clock);
    while ((o_Busy !== 1'b0 || mq.size() != 0) && n < 5000) begin
      @(negedge i_Clock);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%b model_left=%0d required idle", o_Busy, mq.size());
    end
    repeat (3) @(negedge i_Clock);
  endtask

  logic [7:0] lit_single [7];
  logic [7:0] lit_b2b [2][7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    lit_single = '{8'h01, 8'h00, 8'h04, 8'hB0, 8'h0F, 8'h0A, 8'hB0};
    lit_b2b    = '{'{8'h01, 8'h00, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'hF1},
                   '{8'h01, 8'h04, 8'hAF, 8'hFF, 8'h00, 8'h01, 8'h54}};

    // Pin the model's frame builder against hand-computed bytes.
    for (int k = 0; k < 7; k++) begin
      chk("model_single", frame_byte(32'h4B0, 12'hF0A, k), lit_single[k]);
      chk("model_b2b0",   frame_byte(32'd0, 12'hFFF, k),   lit_b2b[0][k]);
      chk("model_b2b1",   frame_byte(32'd307199, 12'h001, k), lit_b2b[1][k]);
    end

    // Reset: 3 cycles high, then release.
    i_Reset     = 1'b1;
    i_Cmd_Valid = 1'b0;
    i_Cmd_Addr  = '0;
    i_Cmd_Data  = '0;
    @(posedge i_Clock);
    #1;
    cmp_en = 1'b1;
    @(negedge i_Clock);
    chk("rst_ready_low", o_Cmd_Ready, 1'b0);
    chk("rst_tx_high",   o_Uart_Tx,   1'b1);
    repeat (2) @(posedge i_Clock);
    #1;
    i_Reset = 1'b0;
    @(negedge i_Clock);
    chk("rel_ready", o_Cmd_Ready,  1'b1);
    chk("rel_tx",    o_Uart_Tx,    1'b1);
    chk("rel_busy",  o_Busy,       1'b0);
    chk("rel_done",  o_Frame_Done, 1'b0);
    chk("rel_err",   o_Cmd_Error,  1'b0);

    // Single write.
    clr();
    send(32'h4B0, 12'hF0A, 1'b0);
    wait_idle();
    chk("single_busy_cycles", busy_cycles, NB * 10 * CPB);
    chk("single_done_cnt",    done_cnt,    1);
    chk("single_nbytes",      dec_q.size(), NB);
    for (int k = 0; k < NB && k < dec_q.size(); k++) chk("single_byte", dec_q[k], lit_single[k]);

    // Out of range: exactly at the depth, and via high address bits.
    clr();
    send(32'd307200, 12'h123, 1'b0);
    @(negedge i_Clock);
    chk("oor_err_pulse", o_Cmd_Error, 1'b1);
    chk("oor_ready",     o_Cmd_Ready, 1'b1);
    chk("oor_tx",        o_Uart_Tx,   1'b1);
    send(32'h0100_0000, 12'h456, 1'b0);
    wait_idle();
    chk("oor_err_cnt",  err_cnt,      2);
    chk("oor_busy",     busy_cycles,  0);
    chk("oor_no_bytes", dec_q.size(), 0);
    chk("oor_no_done",  done_cnt,     0);

    // Back-to-back with valid held high.
    clr();
    send(32'd0, 12'hFFF, 1'b1);
    send(32'd307199, 12'h001, 1'b0);
    wait_idle();
    chk("b2b_done_cnt", done_cnt,     2);
    chk("b2b_busy",     busy_cycles,  2 * NB * 10 * CPB);
    chk("b2b_nbytes",   dec_q.size(), 2 * NB);
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < NB; k++)
        if (f * NB + k < dec_q.size()) chk("b2b_byte", dec_q[f*NB+k], lit_b2b[f][k]);

    // Reset during byte 2's data bits.
    clr();
    send(32'h3A5C1, 12'hABC, 1'b0);
    repeat (95) @(posedge i_Clock);
    #1;
    i_Reset = 1'b1;
    @(posedge i_Clock);
    #1;
    i_Reset = 1'b0;
    @(negedge i_Clock);
    chk("midrst_tx",   o_Uart_Tx, 1'b1);
    chk("midrst_busy", o_Busy,    1'b0);
    repeat (300) @(negedge i_Clock);
    chk("midrst_no_done", done_cnt, 0);
    clr();
    send(32'h12345, 12'h5A5, 1'b0);
    wait_idle();
    chk("post_rst_done",   done_cnt,     1);
    chk("post_rst_nbytes", dec_q.size(), NB);
    for (int k = 0; k < NB && k < dec_q.size(); k++)
      chk("post_rst_byte", dec_q[k], frame_byte(32'h12345, 12'h5A5, k));

    // Randomized traffic, valid also toggling while busy.
    clr();
    for (int cyc = 0; cyc < 6000; cyc++) begin
      int r;
      @(posedge i_Clock);
      #1;
      i_Cmd_Valid = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      if (r == 0)      i_Cmd_Addr = $urandom;
      else if (r == 1) i_Cmd_Addr = 32'(FBD + $urandom_range(0, 3));
      else if (r == 2) i_Cmd_Addr = 32'(FBD - 1);
      else             i_Cmd_Addr = 32'($urandom_range(0, FBD - 1));
      i_Cmd_Data = BPP'($urandom_range(0, 4095));
    end
    @(posedge i_Clock);
    #1;
    i_Cmd_Valid = 1'b0;
    wait_idle();
    chk("rand_nbytes", dec_q.size(), exp_bytes.size());
    for (int k = 0; k < dec_q.size() && k < exp_bytes.size(); k++)
      chk("rand_byte", dec_q[k], exp_bytes[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
